// File: rtl/turbo_pkg.sv
// Shared constants, FSM state type and init-metric helper for the turbo MAP alpha recursion.
package turbo_pkg;

    localparam int unsigned NSTATES  = 8;
    localparam int unsigned MW       = 16;
    localparam int unsigned TMAX_W   = 17;
    localparam int unsigned LEN_W    = 13;
    localparam int          INIT_NEG = -4096;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StRun,
        StFin
    } alpha_st_e;

    // State 0 starts at 0 (known start state); all others start strongly penalised.
    function automatic logic [MW-1:0] init_metric(input int unsigned s);
        logic [MW-1:0] m;
        m = (s == 0) ? '0 : MW'(INIT_NEG);
        return m;
    endfunction

endpackage

// File: rtl/alpha_sat_sub.sv
// Combinational 17-bit signed subtract (a - b) with saturation to MW bits and a sat flag.
module alpha_sat_sub
    import turbo_pkg::*;
(
    input  logic [TMAX_W-1:0] a_i,
    input  logic [TMAX_W-1:0] b_i,
    output logic [MW-1:0]     d_o,
    output logic              sat_o
);

    localparam int unsigned DW = TMAX_W + 1;

    logic [DW-1:0] diff;
    logic [DW-MW:0] hi;

    always_comb begin
        diff  = {a_i[TMAX_W-1], a_i} - {b_i[TMAX_W-1], b_i};
        // Result fits in MW bits only if all bits above the MW-bit sign agree with it.
        hi    = diff[DW-1:MW-1];
        sat_o = !((&hi) || !(|hi));
        if (sat_o) begin
            d_o = diff[DW-1] ? {1'b1, {(MW-1){1'b0}}} : {1'b0, {(MW-1){1'b1}}};
        end else begin
            d_o = diff[MW-1:0];
        end
    end

endmodule

// File: rtl/alpha_norm_reg.sv
// Forward state-metric register: normalises TMAX outputs to state 0, saturates and registers them.
// Optional saturation event counter enabled by defining ALPHA_SAT_CNT_EN.
module alpha_norm_reg
    import turbo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        frame_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NSTATES*TMAX_W-1:0] tmax_in,
    output logic [NSTATES*MW-1:0]   old_metric,
    output logic                    out_valid,
    output logic [LEN_W-1:0]        out_addr,
    output logic [NSTATES*MW-1:0]   out_alpha,
    output logic                    busy,
`ifdef ALPHA_SAT_CNT_EN
    output logic [15:0]             sat_cnt,
`endif
    output logic                    done
);

    alpha_st_e               state_q;
    logic [NSTATES*MW-1:0]   metric_q;
    logic [NSTATES*MW-1:0]   init_vec;
    logic [NSTATES*MW-1:0]   norm;
    logic [NSTATES-1:0]      sat;
    logic [LEN_W-1:0]        step_q;
    logic [LEN_W-1:0]        len_q;
    logic                    out_valid_q;
    logic [LEN_W-1:0]        out_addr_q;
    logic                    done_q;
    logic                    start_acc;
    logic                    step_acc;

    always_comb begin
        init_vec = '0;
        for (int unsigned s = 0; s < NSTATES; s++) begin
            init_vec[s*MW +: MW] = init_metric(s);
        end
    end

    for (genvar g = 0; g < NSTATES; g++) begin : g_sat
        alpha_sat_sub u_sat (
            .a_i   (tmax_in[g*TMAX_W +: TMAX_W]),
            .b_i   (tmax_in[0 +: TMAX_W]),
            .d_o   (norm[g*MW +: MW]),
            .sat_o (sat[g])
        );
    end

    assign start_acc = (state_q == StIdle) && start;
    assign step_acc  = (state_q == StRun) && in_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            metric_q    <= init_vec;
            step_q      <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        len_q       <= frame_len;
                        metric_q    <= init_vec;
                        step_q      <= '0;
                        // Init vector is emitted as step 0 during the INIT cycle.
                        out_valid_q <= 1'b1;
                        out_addr_q  <= '0;
                        state_q     <= StInit;
                    end
                end
                StInit: begin
                    step_q  <= {{(LEN_W-1){1'b0}}, 1'b1};
                    state_q <= (len_q == '0) ? StFin : StRun;
                end
                StRun: begin
                    if (in_valid) begin
                        metric_q    <= norm;
                        out_valid_q <= 1'b1;
                        out_addr_q  <= step_q;
                        step_q      <= step_q + 1'b1;
                        if (step_q == len_q) begin
                            state_q <= StFin;
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ALPHA_SAT_CNT_EN
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            sat_cnt_q <= '0;
        end else if (step_acc && (|sat) && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

    assign in_ready   = (state_q == StRun);
    assign busy       = (state_q == StInit) || (state_q == StRun);
    assign old_metric = metric_q;
    assign out_alpha  = metric_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign done       = done_q;

endmodule

// File: tb/tb_alpha_norm_reg.sv
// Scoreboard bench for alpha_norm_reg; define ALPHA_SAT_CNT_EN to also check sat_cnt.
module tb_alpha_norm_reg;
    import turbo_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      start = 1'b0;
    logic [LEN_W-1:0]          frame_len = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [NSTATES*TMAX_W-1:0] tmax_in = '0;
    logic [NSTATES*MW-1:0]     old_metric;
    logic                      out_valid;
    logic [LEN_W-1:0]          out_addr;
    logic [NSTATES*MW-1:0]     out_alpha;
    logic                      busy;
    logic                      done;
`ifdef ALPHA_SAT_CNT_EN
    logic [15:0]               sat_cnt;
`endif

    alpha_norm_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_len  (frame_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tmax_in    (tmax_in),
        .old_metric (old_metric),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_alpha  (out_alpha),
        .busy       (busy),
`ifdef ALPHA_SAT_CNT_EN
        .sat_cnt    (sat_cnt),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LEN_W-1:0]      addr;
        logic [NSTATES*MW-1:0] alpha;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   vld_cnt = 0;
    int   done_cnt = 0;
    int   last_vld_cyc = 0;
    int   done_cyc = 0;
    bit   ready_seen = 1'b0;
    logic [NSTATES*MW-1:0] ivec;
    int   tv [NSTATES];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NSTATES*TMAX_W-1:0] pack8(input int t [NSTATES]);
        logic [NSTATES*TMAX_W-1:0] v;
        v = '0;
        for (int s = 0; s < NSTATES; s++) v[s*TMAX_W +: TMAX_W] = t[s][TMAX_W-1:0];
        return v;
    endfunction

    // Reference: plain integer subtract and clamp.
    function automatic logic [NSTATES*MW-1:0] model(input logic [NSTATES*TMAX_W-1:0] v);
        logic [NSTATES*MW-1:0] m;
        logic signed [TMAX_W-1:0] x;
        int b, d;
        x = v[0 +: TMAX_W];
        b = int'(x);
        m = '0;
        for (int s = 0; s < NSTATES; s++) begin
            x = v[s*TMAX_W +: TMAX_W];
            d = int'(x) - b;
            if (d > 32767) m[s*MW +: MW] = 16'h7FFF;
            else if (d < -32768) m[s*MW +: MW] = 16'h8000;
            else m[s*MW +: MW] = d[15:0];
        end
        return m;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (in_ready) ready_seen = 1'b1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) begin
            vld_cnt++;
            last_vld_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_addr", out_addr, e.addr);
                check("out_alpha", out_alpha, e.alpha);
                check("old_metric_eq_alpha", old_metric, e.alpha);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input int len);
        exp_t e;
        start = 1'b1;
        frame_len = LEN_W'(len);
        e.addr = '0;
        e.alpha = ivec;
        exp_q.push_back(e);
        tick(1);
        start = 1'b0;
        frame_len = '1;
        check("busy_init", busy, 1);
    endtask

    task automatic send_step(input logic [NSTATES*TMAX_W-1:0] v, input int addr);
        exp_t e;
        int n = 0;
        while (!in_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        tmax_in = v;
        e.addr = LEN_W'(addr);
        e.alpha = model(v);
        exp_q.push_back(e);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, d0;
        logic [NSTATES*MW-1:0] held;
        for (int s = 0; s < NSTATES; s++) ivec[s*MW +: MW] = (s == 0) ? 16'h0000 : 16'hF000;

        // 1: reset, then in_valid without start
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("rst_old_metric", old_metric, ivec);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_done", done, 0);
        v0 = vld_cnt;
        in_valid = 1'b1;
        for (int s = 0; s < NSTATES; s++) tv[s] = 500 * s;
        tmax_in = pack8(tv);
        tick(3);
        in_valid = 1'b0;
        check("idle_no_valid", vld_cnt - v0, 0);
        check("idle_metric_held", old_metric, ivec);

        // 2: normal frame of 3, with a start pulse mid-frame that must be ignored
        start_frame(3);
        for (int k = 1; k <= 3; k++) begin
            for (int s = 0; s < NSTATES; s++) tv[s] = 100 * k + 10 * s;
            send_step(pack8(tv), k);
            if (k == 1) begin
                start = 1'b1;
                frame_len = 13'd7;
            end
        end
        start = 1'b0;
        check("step_metrics", old_metric, 128'h0046_003C_0032_0028_001E_0014_000A_0000);
        wait_done();
        check("done_latency", done_cyc - last_vld_cyc, 1);

        // 3: saturation, exact boundaries, clean step
        start_frame(4);
        tv = '{-65536, 65535, 0, 0, 0, 0, 0, 0};
        send_step(pack8(tv), 1);
        check("sat_pos_state1", old_metric[MW +: MW], 16'h7FFF);
        tv = '{65535, 0, -65536 + 5, -65536, 0, 65535, 1, -1};
        send_step(pack8(tv), 2);
        check("sat_neg_state3", old_metric[3*MW +: MW], 16'h8000);
        tv = '{0, 32767, -32768, 32768, -32769, 1, 2, 3};
        send_step(pack8(tv), 3);
        tv = '{7, 8, 9, 10, 11, 12, 13, 14};
        send_step(pack8(tv), 4);
        wait_done();
`ifdef ALPHA_SAT_CNT_EN
        check("sat_cnt", sat_cnt, 3);
        start_frame(0);
        check("sat_cnt_clear", sat_cnt, 0);
        wait_done();
`endif

        // 4: bubbles 1,0,0,1
        v0 = vld_cnt;
        start_frame(2);
        tv = '{-300, -290, -280, -270, -260, -250, -240, -230};
        send_step(pack8(tv), 1);
        held = model(pack8(tv));
        tv = '{1000, 0, 0, 0, 0, 0, 0, 0};
        tmax_in = pack8(tv);
        tick(2);
        check("bubble_hold", old_metric, held);
        check("bubble_busy", busy, 1);
        tv = '{40, 41, 42, 43, 44, 45, 46, 47};
        send_step(pack8(tv), 2);
        wait_done();
        check("bubble_valid_count", vld_cnt - v0, 3);

        // 5: zero length
        v0 = vld_cnt;
        ready_seen = 1'b0;
        start_frame(0);
        wait_done();
        check("zero_valid_count", vld_cnt - v0, 1);
        check("zero_no_ready", ready_seen, 0);
        check("zero_metric", old_metric, ivec);

        // 6: reset mid-frame, then a full frame
        start_frame(5);
        tv = '{5, 6, 7, 8, 9, 10, 11, 12};
        send_step(pack8(tv), 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("midrst_busy", busy, 0);
        check("midrst_metric", old_metric, ivec);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_sb_empty", exp_q.size(), 0);
        start_frame(2);
        for (int k = 1; k <= 2; k++) begin
            for (int s = 0; s < NSTATES; s++) tv[s] = -20 * k * s + 3;
            send_step(pack8(tv), k);
        end
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
